id_mult1_latch: RTL and testbench



---
 rtl/id_mult1_latch.sv | 164 ++++++++++++++++
 tb/tb_id_mult1_latch.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_mult1_latch.sv
// Decode/issue to mult1 pipeline latch with a valid/ready handshake and a
// one-entry skid buffer; decodes M-extension funct3 into operand-sign flags.
module id_mult1_latch #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            kill_i,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [4:0]      id_write_addr_i,
  input  logic            id_int_write_enable_i,
  input  logic [XLEN-1:0] id_instruction_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic            mult1_ready_i,
  output logic            mult1_valid_o,
  output logic [XLEN-1:0] mult1_rs1_data_o,
  output logic [XLEN-1:0] mult1_rs2_data_o,
  output logic            mult1_signed_a_o,
  output logic            mult1_signed_b_o,
  output logic            mult1_high_o,
  output logic            mult1_illegal_o,
  output logic [4:0]      mult1_write_addr_o,
  output logic            mult1_int_write_enable_o,
  output logic [XLEN-1:0] mult1_instruction_o,
  output logic [XLEN-1:0] mult1_pc_o
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [4:0]      waddr;
    logic            wen;
    logic            signed_a;
    logic            signed_b;
    logic            high;
    logic            illegal;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   ready_q, ready_d;
  logic   in_fire, out_fire;
  entry_t in_entry;

  // Sign/high flags and the qualified write enable are resolved at capture so
  // mult1 sees plain control bits.
  function automatic entry_t capture(
    input logic [XLEN-1:0] rs1,
    input logic [XLEN-1:0] rs2,
    input logic [4:0]      waddr,
    input logic            wen,
    input logic [XLEN-1:0] instr,
    input logic [XLEN-1:0] pc
  );
    entry_t     e;
    logic [2:0] f3;
    f3         = instr[14:12];
    e.rs1      = rs1;
    e.rs2      = rs2;
    e.instr    = instr;
    e.pc       = pc;
    e.waddr    = waddr;
    e.illegal  = f3[2];
    e.signed_a = 1'b0;
    e.signed_b = 1'b0;
    e.high     = 1'b0;
    case (f3)
      3'b000:  begin e.signed_a = 1'b1; e.signed_b = 1'b1; end
      3'b001:  begin e.signed_a = 1'b1; e.signed_b = 1'b1; e.high = 1'b1; end
      3'b010:  begin e.signed_a = 1'b1; e.high = 1'b1; end
      3'b011:  e.high = 1'b1;
      default: ;
    endcase
    e.wen = wen & (waddr != 5'd0) & ~e.illegal;
    return e;
  endfunction

  assign in_entry = capture(id_rs1_data_i, id_rs2_data_i, id_write_addr_i,
                            id_int_write_enable_i, id_instruction_i, id_pc_i);

  assign mult1_valid_o = (state_q != EMPTY);
  assign in_fire       = id_valid_i & ready_q;
  assign out_fire      = mult1_valid_o & mult1_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (kill_i) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_entry;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_entry;
          end else if (in_fire) begin
            state_d = TWO;
            skid_d  = in_entry;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = '0;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
    ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  // MAIN is cleared whenever the latch empties, so bubbles present zeros.
  assign id_ready_o               = ready_q;
  assign mult1_rs1_data_o         = main_q.rs1;
  assign mult1_rs2_data_o         = main_q.rs2;
  assign mult1_signed_a_o         = main_q.signed_a;
  assign mult1_signed_b_o         = main_q.signed_b;
  assign mult1_high_o             = main_q.high;
  assign mult1_illegal_o          = main_q.illegal;
  assign mult1_write_addr_o       = main_q.waddr;
  assign mult1_int_write_enable_o = main_q.wen;
  assign mult1_instruction_o      = main_q.instr;
  assign mult1_pc_o               = main_q.pc;

endmodule

// File: tb/tb_id_mult1_latch.sv
// Self-checking bench for id_mult1_latch: directed scenarios plus randomized
// traffic against a FIFO-style reference model of the two-entry latch.
module tb_id_mult1_latch;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            kill = 1'b0;
  logic            id_valid = 1'b0;
  logic            id_ready;
  logic [XLEN-1:0] rs1 = '0, rs2 = '0, instr = '0, pc = '0;
  logic [4:0]      waddr = '0;
  logic            we = 1'b0;
  logic            m_ready = 1'b0;
  logic            m_valid;
  logic [XLEN-1:0] o_rs1, o_rs2, o_instr, o_pc;
  logic            o_sa, o_sb, o_high, o_ill, o_wen;
  logic [4:0]      o_waddr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_mult1_latch #(.XLEN(XLEN)) dut (
    .clk_i(clk), .rst_i(rst), .kill_i(kill),
    .id_valid_i(id_valid), .id_ready_o(id_ready),
    .id_rs1_data_i(rs1), .id_rs2_data_i(rs2),
    .id_write_addr_i(waddr), .id_int_write_enable_i(we),
    .id_instruction_i(instr), .id_pc_i(pc),
    .mult1_ready_i(m_ready), .mult1_valid_o(m_valid),
    .mult1_rs1_data_o(o_rs1), .mult1_rs2_data_o(o_rs2),
    .mult1_signed_a_o(o_sa), .mult1_signed_b_o(o_sb),
    .mult1_high_o(o_high), .mult1_illegal_o(o_ill),
    .mult1_write_addr_o(o_waddr), .mult1_int_write_enable_o(o_wen),
    .mult1_instruction_o(o_instr), .mult1_pc_o(o_pc)
  );

  wire [139:0] obs = {id_ready, m_valid, o_rs1, o_rs2, o_sa, o_sb, o_high,
                      o_ill, o_waddr, o_wen, o_instr, o_pc};
  localparam logic [139:0] RESET_VEC = {1'b1, 139'b0};

  // Reference model: accepted instructions in order, at most two outstanding.
  typedef struct {
    logic [XLEN-1:0] rs1, rs2, instr, pc;
    logic [4:0]      wa;
    logic            we;
  } item_t;

  item_t mq[$];
  bit    m_rdy, m_of, m_if;

  always @(posedge clk or posedge rst) begin
    if (rst || kill) begin
      mq.delete();
    end else begin
      m_rdy = (mq.size() < 2);
      m_of  = (mq.size() > 0) && m_ready;
      m_if  = id_valid && m_rdy;
      if (m_of) void'(mq.pop_front());
      if (m_if) mq.push_back('{rs1: rs1, rs2: rs2, instr: instr, pc: pc, wa: waddr, we: we});
    end
  end

  function automatic logic [139:0] exp_vec();
    item_t      e;
    logic [2:0] f3;
    logic       ill, sa, sb, hi, wen;
    if (mq.size() == 0) return RESET_VEC;
    e   = mq[0];
    f3  = e.instr[14:12];
    ill = f3[2];
    sa  = !ill && (f3 != 3'b011);
    sb  = !ill && !f3[1];
    hi  = !ill && (f3 != 3'b000);
    wen = e.we && (e.wa != 5'd0) && !ill;
    return {(mq.size() < 2), 1'b1, e.rs1, e.rs2, sa, sb, hi, ill, e.wa, wen,
            e.instr, e.pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [2:0] f3, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [4:0] wa,
                       input logic [XLEN-1:0] p);
    id_valid = 1'b1;
    rs1      = a;
    rs2      = b;
    waddr    = wa;
    we       = 1'b1;
    pc       = p;
    instr    = {17'h0, f3, 12'h033} | 32'h0200_0000;
  endtask

  task automatic idle_inputs();
    id_valid = 1'b0;
    rs1 = '0; rs2 = '0; waddr = '0; we = 1'b0; instr = '0; pc = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    m_ready = 1'b1;
    repeat (2) tick();
    total++;
    if (obs !== RESET_VEC) begin
      bad++;
      $display("FAIL reset_hold obs=%h exp=%h", obs, RESET_VEC);
    end
    rst = 1'b0;
    repeat (2) tick();
    total++;
    if (obs !== RESET_VEC) begin
      bad++;
      $display("FAIL reset_idle obs=%h exp=%h", obs, RESET_VEC);
    end
  endtask

  task automatic test_mulhsu();
    m_ready = 1'b1;
    offer(3'b010, 32'hFFFF_FFFE, 32'h3, 5'd5, 32'h0000_0040);
    tick();
    idle_inputs();
    total++;
    if ({m_valid, o_sa, o_sb, o_high, o_ill, o_wen} !== 6'b110101) begin
      bad++;
      $display("FAIL mulhsu_flags obs=%b exp=110101", {m_valid, o_sa, o_sb, o_high, o_ill, o_wen});
    end
    total++;
    if (obs !== exp_vec() || o_rs1 !== 32'hFFFF_FFFE || o_pc !== 32'h40) begin
      bad++;
      $display("FAIL mulhsu_payload obs=%h exp=%h", obs, exp_vec());
    end
    tick();
    total++;
    if (obs !== RESET_VEC) begin
      bad++;
      $display("FAIL mulhsu_bubble obs=%h exp=%h", obs, RESET_VEC);
    end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] seen[$];
    m_ready = 1'b0;
    offer(3'b000, 32'h11, 32'h22, 5'd1, 32'h100);
    tick();
    offer(3'b001, 32'h33, 32'h44, 5'd2, 32'h104);
    tick();
    total++;
    if (id_ready !== 1'b0 || o_pc !== 32'h100) begin
      bad++;
      $display("FAIL stall_full obs=ready:%b pc:%h exp=ready:0 pc:100", id_ready, o_pc);
    end
    offer(3'b011, 32'h55, 32'h66, 5'd3, 32'h108);
    tick();
    total++;
    if (obs !== exp_vec() || o_pc !== 32'h100) begin
      bad++;
      $display("FAIL stall_hold obs=%h exp=%h", obs, exp_vec());
    end
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (m_valid) seen.push_back(o_pc);
      if (id_valid && id_ready) begin
        tick();
        idle_inputs();
      end else begin
        tick();
      end
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL stall_drain[%0d] obs=%h exp=%h", i, obs, exp_vec());
      end
    end
    total++;
    if (seen.size() != 3 || seen[0] !== 32'h100 || seen[1] !== 32'h104 || seen[2] !== 32'h108) begin
      bad++;
      $display("FAIL stall_order obs=count:%0d exp=count:3 order 100,104,108", seen.size());
    end
  endtask

  task automatic test_kill();
    m_ready = 1'b0;
    offer(3'b000, 32'h1, 32'h2, 5'd4, 32'h200);
    tick();
    offer(3'b001, 32'h3, 32'h4, 5'd4, 32'h204);
    tick();
    m_ready = 1'b1;
    kill    = 1'b1;
    offer(3'b010, 32'h5, 32'h6, 5'd4, 32'h208);
    tick();
    kill = 1'b0;
    idle_inputs();
    total++;
    if (obs !== RESET_VEC) begin
      bad++;
      $display("FAIL kill_flush obs=%h exp=%h", obs, RESET_VEC);
    end
    repeat (2) tick();
    total++;
    if (m_valid !== 1'b0 || o_pc !== 32'h0) begin
      bad++;
      $display("FAIL kill_dropped obs=valid:%b pc:%h exp=valid:0 pc:0", m_valid, o_pc);
    end
  endtask

  task automatic test_wen();
    m_ready = 1'b1;
    offer(3'b000, 32'h7, 32'h8, 5'd0, 32'h300);
    tick();
    total++;
    if (m_valid !== 1'b1 || o_wen !== 1'b0) begin
      bad++;
      $display("FAIL wen_x0 obs=valid:%b wen:%b exp=valid:1 wen:0", m_valid, o_wen);
    end
    offer(3'b100, 32'h9, 32'hA, 5'd7, 32'h304);
    tick();
    idle_inputs();
    total++;
    if ({m_valid, o_ill, o_wen, o_sa, o_sb, o_high} !== 6'b110000 || o_waddr !== 5'd7) begin
      bad++;
      $display("FAIL wen_div obs=%b addr:%0d exp=110000 addr:7", {m_valid, o_ill, o_wen, o_sa, o_sb, o_high}, o_waddr);
    end
    tick();
  endtask

  task automatic test_async_reset();
    m_ready = 1'b0;
    offer(3'b001, 32'hAA, 32'hBB, 5'd9, 32'h400);
    tick();
    offer(3'b011, 32'hCC, 32'hDD, 5'd9, 32'h404);
    tick();
    idle_inputs();
    total++;
    if (id_ready !== 1'b0 || m_valid !== 1'b1) begin
      bad++;
      $display("FAIL async_setup obs=ready:%b valid:%b exp=ready:0 valid:1", id_ready, m_valid);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs !== RESET_VEC) begin
      bad++;
      $display("FAIL async_reset obs=%h exp=%h", obs, RESET_VEC);
    end
    #1 rst = 1'b0;
    m_ready = 1'b1;
    tick();
    total++;
    if (obs !== RESET_VEC) begin
      bad++;
      $display("FAIL async_after obs=%h exp=%h", obs, RESET_VEC);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      m_ready  = ($urandom_range(0, 2) != 0);
      kill     = ($urandom_range(0, 24) == 0);
      rs1      = $urandom;
      rs2      = $urandom;
      instr    = $urandom;
      pc       = $urandom;
      waddr    = 5'($urandom_range(0, 31));
      we       = $urandom_range(0, 1) == 1;
      tick();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL random[%0d] obs=%h exp=%h", i, obs, exp_vec());
      end
    end
    kill = 1'b0;
    idle_inputs();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mulhsu();
    test_back_to_back();
    test_kill();
    test_wen();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
